// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the five-stage pipeline. It holds the
//               datapath widths, the bubble encoding, the fetch state
//               encoding and a word-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int C_PC_W   = 32;
    localparam int C_DATA_W = 32;

    // sll $0,$0,0
    localparam logic [C_DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_KILL = 2'd3
    } fetch_state_e;

    // Instruction addresses are always word aligned, so the low two bits are dropped.
    function automatic logic [C_PC_W-1:0] align_word(input logic [C_PC_W-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction fetch unit. It holds the fetch PC, runs the
//               req/ack handshake with instruction memory and presents
//               pc/instr to IF/ID, or a NOP bubble when nothing is ready.
//               Optional macro IF_FETCH_PREFETCH_EN issues the next request
//               combinationally in the cycle an instruction is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cu_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        fetch_valid
);

    import pipe_pkg::*;

    fetch_state_e      r_state;
    logic [C_PC_W-1:0] r_pc;        // fetch PC; also the outstanding request address
    logic [C_PC_W-1:0] r_tgt;       // redirect target latched while killing a request
    logic [31:0]       r_instr;
    logic              r_req;
    logic              r_valid;

    fetch_state_e      w_state_nxt;
    logic [C_PC_W-1:0] w_pc_nxt;
    logic [C_PC_W-1:0] w_tgt_nxt;
    logic [31:0]       w_instr_nxt;
    logic [C_PC_W-1:0] w_target;
    logic [C_PC_W-1:0] w_pc_inc;
    logic              w_pf_fire;

    assign w_target = align_word(redirect_pc);
    assign w_pc_inc = r_pc + 32'd4;

`ifdef IF_FETCH_PREFETCH_EN
    // The next request goes out in the same cycle the held instruction is consumed.
    assign w_pf_fire = (r_state == ST_HOLD) && !cu_stall && !redirect_valid;
    assign imem_req  = r_req | w_pf_fire;
    assign imem_addr = w_pf_fire ? w_pc_inc : r_pc;
`else
    assign w_pf_fire = 1'b0;
    assign imem_req  = r_req;
    assign imem_addr = r_pc;
`endif

    assign pc          = r_pc;
    assign instr       = r_instr;
    assign fetch_valid = r_valid;

    // Next-state logic: a redirect always wins over stall and consumption.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_tgt_nxt   = r_tgt;
        w_instr_nxt = r_instr;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_REQ;
                if (redirect_valid) w_pc_nxt = w_target;
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        // Data for the old path arrived with the redirect: drop it.
                        w_pc_nxt    = w_target;
                        w_state_nxt = ST_REQ;
                    end else begin
                        // Request still in flight: wait it out before moving on.
                        w_tgt_nxt   = w_target;
                        w_state_nxt = ST_KILL;
                    end
                end else if (imem_ack) begin
                    w_instr_nxt = imem_rdata;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = ST_REQ;
                end else if (!cu_stall) begin
                    w_pc_nxt = w_pc_inc;
                    if (w_pf_fire && imem_ack) begin
                        w_instr_nxt = imem_rdata;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            ST_KILL: begin
                if (redirect_valid) w_tgt_nxt = w_target;
                if (imem_ack) begin
                    w_pc_nxt    = redirect_valid ? w_target : r_tgt;
                    w_state_nxt = ST_REQ;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_tgt   <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_tgt   <= w_tgt_nxt;
            r_req   <= (w_state_nxt == ST_REQ) || (w_state_nxt == ST_KILL);
            r_valid <= (w_state_nxt == ST_HOLD);
            r_instr <= (w_state_nxt == ST_HOLD) ? w_instr_nxt : NOP_INSTR;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch
// Description : Self-checking bench for if_fetch with a variable-latency
//               instruction memory model and an in-order scoreboard of the
//               instructions expected to be consumed by IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    localparam logic [31:0] C_RST_PC = 32'h0000_0000;
    localparam logic [31:0] C_NOP    = 32'h0000_0000;
`ifdef IF_FETCH_PREFETCH_EN
    localparam int C_CADENCE = 1;
`else
    localparam int C_CADENCE = 2;
`endif

    logic        clk            = 1'b0;
    logic        reset_n        = 1'b0;
    logic        cu_stall       = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack       = 1'b0;
    logic [31:0] imem_rdata     = 32'h0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fetch_valid;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t sb_q[$];
    int   pop_t[$];
    int   n_chk     = 0;
    int   n_pass    = 0;
    int   cyc       = 0;
    int   mem_delay = 0;
    int   wcnt      = 0;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cu_stall       (cu_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .pc             (pc),
        .instr          (instr),
        .fetch_valid    (fetch_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
    endfunction

    // Memory model: acks after mem_delay waiting cycles of a held request.
    always @(negedge clk) begin
        if (imem_ack || !reset_n) wcnt = 0;
        imem_ack = 1'b0;
        if (reset_n && imem_req) begin
            if (wcnt >= mem_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                wcnt = wcnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock: consumption monitor at the falling edge, return just after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (reset_n && fetch_valid && !cu_stall && !redirect_valid) begin
            n_chk++;
            assert (sb_q.size() != 0) n_pass++;
            else $error("FAIL unexpected_fetch: observed pc %h instr %h, expected no consumption", pc, instr);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_pc", pc, e.pc);
                chk("sb_instr", instr, e.word);
                pop_t.push_back(cyc);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.word = mem_word(a);
        sb_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
        chk("drain_left", sb_q.size(), 0);
    endtask

    task automatic settle();
        cu_stall = 1'b1;
        for (int i = 0; i < 30 && !fetch_valid; i++) tick();
        chk("settle_hold", {31'd0, fetch_valid}, 32'd1);
    endtask

    task automatic redirect_to(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
        chk({tag, "_addr"},  imem_addr,            C_RST_PC);
        chk({tag, "_pc"},    pc,                   C_RST_PC);
        chk({tag, "_instr"}, instr,                C_NOP);
        chk({tag, "_valid"}, {31'd0, fetch_valid}, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        chk_reset_vals("rst");

        // Zero-wait sequential fetch from reset
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        pop_t.delete();
        reset_n = 1'b1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, C_RST_PC);
        drain(20);
        cu_stall = 1'b1;
        chk("pop_count", pop_t.size(), 3);
        chk("cadence_1", pop_t[1] - pop_t[0], C_CADENCE);
        chk("cadence_2", pop_t[2] - pop_t[1], C_CADENCE);

        // Three-cycle wait memory at 0x40
        settle();
        mem_delay = 3;
        push_exp(32'h40);
        redirect_to(32'h40);
        cu_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, 32'h40);
            chk("wait_valid", {31'd0, fetch_valid}, 32'd0);
            chk("wait_instr", instr, C_NOP);
            tick();
        end
        chk("wait_done_valid", {31'd0, fetch_valid}, 32'd1);
        chk("wait_done_instr", instr, mem_word(32'h40));
        chk("wait_done_pc", pc, 32'h40);
        drain(5);

        // Stall for three cycles in HOLD at 0x10
        settle();
        mem_delay = 0;
        redirect_to(32'h10);
        tick();
        chk("stall_valid", {31'd0, fetch_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc, 32'h10);
            chk("stall_instr", instr, mem_word(32'h10));
            chk("stall_noreq", {31'd0, imem_req}, 32'd0);
        end
        push_exp(32'h10);
        cu_stall = 1'b0;
        tick();
`ifdef IF_FETCH_PREFETCH_EN
        chk("after_stall_valid", {31'd0, fetch_valid}, 32'd1);
        chk("after_stall_pc", pc, 32'h14);
`else
        chk("after_stall_req", {31'd0, imem_req}, 32'd1);
        chk("after_stall_addr", imem_addr, 32'h14);
`endif
        cu_stall = 1'b1;
        chk("stall_sb_left", sb_q.size(), 0);

        // Redirect while a request to 0x20 is outstanding
        settle();
        mem_delay = 2;
        redirect_to(32'h20);
        cu_stall       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        chk("kill_req", {31'd0, imem_req}, 32'd1);
        chk("kill_addr", imem_addr, 32'h20);
        chk("kill_valid", {31'd0, fetch_valid}, 32'd0);
        push_exp(32'h200);
        for (int i = 0; i < 10 && !(imem_req && imem_addr == 32'h200); i++) tick();
        chk("redir_addr", imem_addr, 32'h200);
        drain(20);
        cu_stall = 1'b1;

        // Unaligned redirect during a stall in HOLD
        settle();
        mem_delay = 0;
        redirect_to(32'h103);
        chk("align_req", {31'd0, imem_req}, 32'd1);
        chk("align_addr", imem_addr, 32'h100);
        chk("align_pc", pc, 32'h100);
        chk("align_valid", {31'd0, fetch_valid}, 32'd0);
        push_exp(32'h100);
        cu_stall = 1'b0;
        drain(10);

        // PC wrap at the top of the address space
        settle();
        redirect_to(32'hFFFF_FFFC);
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0000_0000);
        cu_stall = 1'b0;
        drain(20);

        // Asynchronous reset in the middle of a memory wait
        settle();
        mem_delay = 3;
        redirect_to(32'h80);
        tick();
        reset_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        mem_delay = 0;
        tick();
        reset_n = 1'b1;
        chk("rel_idle_req", {31'd0, imem_req}, 32'd0);
        push_exp(C_RST_PC);
        cu_stall = 1'b0;
        tick();
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, C_RST_PC);
        drain(10);
        cu_stall = 1'b1;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
